decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised LA32R decode stage that replaces the single-cycle, unregistered decode/regfile wrapper. It accepts one instruction per cycle from fetch over a valid/ready handshake and decodes a fixed LA32R subset. It reads operands from an internal 32×32 register file fed by `NWB` writeback ports, and presents the result to execute through a registered, stallable, flushable output slot. Optionally, it bypasses same-cycle writebacks into the operands it captures or holds.

## Interface
- `NWB`, default 2: number of writeback ports, range 1–4.
- `XLEN`, default 32: datapath width; only 32 is supported.
- `clk`  in  1: the single clock; everything samples on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: fetch presents an instruction.
- `in_ready`  out  1: decode accepts it this cycle.
- `in_pc`  in  32: PC of the instruction.
- `in_inst`  in  32: instruction word.
- `flush`  in  1: kill the held entry and any entry accepted this cycle.
- `out_valid`  out  1: decoded entry is valid.
- `out_ready`  in  1: execute consumes the entry.
- `out_pc`  out  32: passed-through PC.
- `out_imm`  out  32: extended immediate.
- `out_rj`  out  32: operand A.
- `out_rk`  out  32: operand B.
- `out_rd_idx`  out  5: destination register.
- `out_exe_type`  out  2: 0 = ALU, 1 = MEM, 2 = BR, 3 = none.
- `out_exe_op`  out  4: sub-op within the type.
- `out_mem_rw`  out  2: 01 = load, 10 = store, 00 = none.
- `out_wb_valid`  out  1: instruction writes `out_rd_idx`.
- `out_illegal`  out  1: instruction is not in the subset.
- `wb_we`  in  NWB: per-port write enable.
- `wb_idx`  in  5·NWB: per-port register index; port p uses bits [5p+4:5p].
- `wb_data`  in  32·NWB: per-port write data; port p uses bits [32p+31:32p].

## Operation
- **Handshake.** `in_ready = !out_valid || out_ready`. The transfer occurs when `in_valid && in_ready`.
- **Decode.** Keys on the opcode fields below. Anything else is illegal.
  - ADD.W: `inst[31:15]`=0x20. ALU, op 0.
  - SUB.W: `inst[31:15]`=0x22. ALU, op 1.
  - ADDI.W: `inst[31:22]`=0x00A. ALU, op 0.
  - LU12I.W: `inst[31:25]`=0x0A. ALU, op 2.
  - LD.W: `inst[31:22]`=0x0A2. MEM, op 0, `out_mem_rw`=01.
  - ST.W: `inst[31:22]`=0x0A6. MEM, op 1, `out_mem_rw`=10.
  - BEQ: `inst[31:26]`=0x16. BR, op 0.
  - B: `inst[31:26]`=0x14. BR, op 1.
  - BL: `inst[31:26]`=0x15. BR, op 2.
- **Register indices.**
  - rj = `inst[9:5]`.
  - The second read index is `inst[4:0]` (rd) for ST.W and BEQ, and `inst[14:10]` (rk) otherwise.
  - `out_rd_idx` = `inst[4:0]`, except 1 for BL.
- **Immediates.**
  - ADDI.W, LD.W, ST.W: sign-extended `inst[21:10]`.
  - LU12I.W: `{inst[24:5], 12'b0}`.
  - BEQ: sign-extended `{inst[25:10], 2'b00}`.
  - B, BL: sign-extended `{inst[9:0], inst[25:10], 2'b00}`.
  - Register-register ops: 0.
- **Writeback flag.** `out_wb_valid`=1 for ADD.W, SUB.W, ADDI.W, LU12I.W, LD.W and BL, but forced to 0 when the destination index is 0.
- **Illegal instruction.**
  - `out_exe_type`=3, `out_exe_op`=0, `out_mem_rw`=00, `out_wb_valid`=0, `out_illegal`=1.
  - The entry still flows through normally.
- **Register file.**
  - r0 always reads 0, and writes to it are ignored.
  - Port p writes when `wb_we[p]` is set.
  - If several ports target the same index in one cycle, the highest-numbered port wins.
- **Flush.**
  - Takes priority over everything.
  - Next cycle `out_valid`=0, and any same-cycle input transfer is discarded.
  - Register-file writes in a flush cycle still occur.

## Timing
- **Reset.** On `rst`, the next edge sets `out_valid`=0, every other output to 0 and all 32 registers to 0. `in_ready` is 1 after reset.
- **Latency.** One cycle: an instruction accepted at edge N appears on the outputs after edge N.
- **Throughput.** One instruction per cycle while `out_ready`=1.
- **Stall.** While `out_valid && !out_ready`, every output holds its value, except for the snoop described under Configuration.
- **Simultaneous events.**
  - Consume and accept in the same cycle: the output is replaced with no bubble.
  - Consume without accept: `out_valid` drops to 0.
- **Regfile write timing.** A writeback is visible to a register-file read in the cycle after the write.

## Configuration
- **`DECODE_WB_BYPASS_EN` defined:**
  - On accept, an operand whose index matches an active `wb_idx` port (index ≠ 0) captures that port's `wb_data`, using the highest-numbered matching port.
  - While stalled, a held `out_rj`/`out_rk` whose source index matches an active port is updated with that data on the same edge.
  - This requires the source indices to be registered alongside the entry.
- **Undefined:**
  - Operands capture the register-file contents as of the previous edge.
  - Held operands never change.
  - Producer/consumer spacing of at least one cycle is the hazard unit's responsibility.

## Test plan
- **Reset and accept.** Assert `rst`, then accept ADDI.W r4, r0, -1 (0x02BFFC04) → `out_valid`=1, `out_imm`=0xFFFFFFFF, `out_rd_idx`=4, `out_wb_valid`=1, `out_exe_type`=0.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 throughout and outputs are stable. Release → the next entry follows with no bubble.
- **Flush.** Assert `flush` in the same cycle as an accept → `out_valid`=0 next cycle, and the flushed entry never appears.
- **Writeback collision.** Port 0 and port 1 both write r5 (0x11, 0x22) → a later ADD.W reading r5 gets 0x22. A write to r0 with 0xFF → r0 still reads 0.
- **Bypass, same-cycle and stalled.** Write r6=0xABCD in the accept cycle of ADD.W r7, r6, r6 → with the macro, `out_rj`=`out_rk`=0xABCD. Without the macro, both hold the old value. Then, stalled, write r6=0x1234 → with the macro, both operands update to 0x1234. Without the macro, both hold.
- **Illegal and BL.** Decode 0xFFFFFFFF → `out_illegal`=1, `out_exe_type`=3, `out_wb_valid`=0. Decode BL offset +8 → `out_rd_idx`=1, `out_imm`=0x00000008.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - LA32R decode stage with regfile and registered stallable output slot
// Optional same-cycle/stall writeback bypass: DECODE_WB_BYPASS_EN
module decode_stage #(
    parameter int NWB  = 2,
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_pc,
    input  logic [31:0]         in_inst,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_pc,
    output logic [XLEN-1:0]     out_imm,
    output logic [XLEN-1:0]     out_rj,
    output logic [XLEN-1:0]     out_rk,
    output logic [4:0]          out_rd_idx,
    output logic [1:0]          out_exe_type,
    output logic [3:0]          out_exe_op,
    output logic [1:0]          out_mem_rw,
    output logic                out_wb_valid,
    output logic                out_illegal,
    input  logic [NWB-1:0]      wb_we,
    input  logic [5*NWB-1:0]    wb_idx,
    input  logic [XLEN*NWB-1:0] wb_data
);
    localparam logic [1:0] T_ALU = 2'd0, T_MEM = 2'd1, T_BR = 2'd2, T_NONE = 2'd3;

    logic [XLEN-1:0] regs [32];

    logic [1:0]      d_type;
    logic [3:0]      d_op;
    logic [1:0]      d_mem;
    logic            d_wb;
    logic            d_ill;
    logic            use_rd;
    logic [4:0]      d_rd;
    logic [XLEN-1:0] d_imm;
    logic [4:0]      src_j;
    logic [4:0]      src_k;
    logic [XLEN-1:0] cap_rj;
    logic [XLEN-1:0] cap_rk;
    logic            accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        d_type = T_NONE;
        d_op   = 4'd0;
        d_mem  = 2'b00;
        d_wb   = 1'b0;
        d_ill  = 1'b0;
        use_rd = 1'b0;
        d_rd   = in_inst[4:0];
        d_imm  = '0;
        if (in_inst[31:15] == 17'h00020) begin
            d_type = T_ALU;
            d_wb   = 1'b1;
        end else if (in_inst[31:15] == 17'h00022) begin
            d_type = T_ALU;
            d_op   = 4'd1;
            d_wb   = 1'b1;
        end else if (in_inst[31:22] == 10'h00A) begin
            d_type = T_ALU;
            d_wb   = 1'b1;
            d_imm  = {{20{in_inst[21]}}, in_inst[21:10]};
        end else if (in_inst[31:25] == 7'h0A) begin
            d_type = T_ALU;
            d_op   = 4'd2;
            d_wb   = 1'b1;
            d_imm  = {in_inst[24:5], 12'b0};
        end else if (in_inst[31:22] == 10'h0A2) begin
            d_type = T_MEM;
            d_mem  = 2'b01;
            d_wb   = 1'b1;
            d_imm  = {{20{in_inst[21]}}, in_inst[21:10]};
        end else if (in_inst[31:22] == 10'h0A6) begin
            d_type = T_MEM;
            d_op   = 4'd1;
            d_mem  = 2'b10;
            use_rd = 1'b1;
            d_imm  = {{20{in_inst[21]}}, in_inst[21:10]};
        end else if (in_inst[31:26] == 6'h16) begin
            d_type = T_BR;
            use_rd = 1'b1;
            d_imm  = {{14{in_inst[25]}}, in_inst[25:10], 2'b00};
        end else if (in_inst[31:26] == 6'h14) begin
            d_type = T_BR;
            d_op   = 4'd1;
            d_imm  = {{4{in_inst[9]}}, in_inst[9:0], in_inst[25:10], 2'b00};
        end else if (in_inst[31:26] == 6'h15) begin
            d_type = T_BR;
            d_op   = 4'd2;
            d_wb   = 1'b1;
            d_rd   = 5'd1;
            d_imm  = {{4{in_inst[9]}}, in_inst[9:0], in_inst[25:10], 2'b00};
        end else begin
            d_ill  = 1'b1;
        end
        if (d_rd == 5'd0) d_wb = 1'b0;
    end

    assign src_j = in_inst[9:5];
    assign src_k = use_rd ? in_inst[4:0] : in_inst[14:10];

`ifdef DECODE_WB_BYPASS_EN
    logic [4:0]      held_j;
    logic [4:0]      held_k;
    logic [XLEN-1:0] hold_rj;
    logic [XLEN-1:0] hold_rk;

    // Ascending port order lets the highest-numbered matching port win.
    always_comb begin
        cap_rj  = regs[src_j];
        cap_rk  = regs[src_k];
        hold_rj = out_rj;
        hold_rk = out_rk;
        for (int p = 0; p < NWB; p++) begin
            if (wb_we[p] && wb_idx[5*p +: 5] != 5'd0) begin
                if (wb_idx[5*p +: 5] == src_j)  cap_rj  = wb_data[XLEN*p +: XLEN];
                if (wb_idx[5*p +: 5] == src_k)  cap_rk  = wb_data[XLEN*p +: XLEN];
                if (wb_idx[5*p +: 5] == held_j) hold_rj = wb_data[XLEN*p +: XLEN];
                if (wb_idx[5*p +: 5] == held_k) hold_rk = wb_data[XLEN*p +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_j <= 5'd0;
            held_k <= 5'd0;
        end else if (!flush && accept) begin
            held_j <= src_j;
            held_k <= src_k;
        end
    end
`else
    assign cap_rj = regs[src_j];
    assign cap_rk = regs[src_k];
`endif

    // r0 is never written, so its reset value of zero is what every read returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) regs[r] <= '0;
        end else begin
            for (int p = 0; p < NWB; p++) begin
                if (wb_we[p] && wb_idx[5*p +: 5] != 5'd0)
                    regs[wb_idx[5*p +: 5]] <= wb_data[XLEN*p +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_imm      <= '0;
            out_rj       <= '0;
            out_rk       <= '0;
            out_rd_idx   <= '0;
            out_exe_type <= '0;
            out_exe_op   <= '0;
            out_mem_rw   <= '0;
            out_wb_valid <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid    <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_imm      <= d_imm;
            out_rj       <= cap_rj;
            out_rk       <= cap_rk;
            out_rd_idx   <= d_rd;
            out_exe_type <= d_type;
            out_exe_op   <= d_op;
            out_mem_rw   <= d_mem;
            out_wb_valid <= d_wb;
            out_illegal  <= d_ill;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end else begin
`ifdef DECODE_WB_BYPASS_EN
            out_rj       <= hold_rj;
            out_rk       <= hold_rk;
`endif
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage against a behavioural LA32R model
module tb_decode_stage;
    localparam int NWB = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_pc = '0;
    logic [31:0]       in_inst = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_pc, out_imm, out_rj, out_rk;
    logic [4:0]        out_rd_idx;
    logic [1:0]        out_exe_type;
    logic [3:0]        out_exe_op;
    logic [1:0]        out_mem_rw;
    logic              out_wb_valid;
    logic              out_illegal;
    logic [NWB-1:0]    wb_we = '0;
    logic [5*NWB-1:0]  wb_idx = '0;
    logic [32*NWB-1:0] wb_data = '0;

    decode_stage #(.NWB(NWB), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_imm(out_imm), .out_rj(out_rj), .out_rk(out_rk),
        .out_rd_idx(out_rd_idx), .out_exe_type(out_exe_type),
        .out_exe_op(out_exe_op), .out_mem_rw(out_mem_rw),
        .out_wb_valid(out_wb_valid), .out_illegal(out_illegal),
        .wb_we(wb_we), .wb_idx(wb_idx), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, imm, rj, rk;
        logic [4:0]  rd, ja, ka;
        logic [1:0]  typ, mem;
        logic [3:0]  op;
        logic        wb, ill;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mregs [32];
    bit          slot_full;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        if (v[bits-1]) return v - (32'd1 << bits);
        return v;
    endfunction

    // Field extraction by shifting and masking the instruction word.
    function automatic exp_t ref_decode(input logic [31:0] i);
        exp_t e;
        logic [31:0] off26;
        e.pc = 0; e.rj = 0; e.rk = 0; e.imm = 0;
        e.rd = i[4:0]; e.ja = i[9:5]; e.ka = i[14:10];
        e.typ = 2'd3; e.op = 0; e.mem = 0; e.wb = 0; e.ill = 0;
        off26 = ((i & 32'h3FF) << 16) | ((i >> 10) & 32'hFFFF);
        if ((i >> 15) == 32'h20) begin
            e.typ = 0; e.wb = 1;
        end else if ((i >> 15) == 32'h22) begin
            e.typ = 0; e.op = 1; e.wb = 1;
        end else if ((i >> 22) == 32'h00A) begin
            e.typ = 0; e.wb = 1; e.imm = sext((i >> 10) & 32'hFFF, 12);
        end else if ((i >> 25) == 32'h0A) begin
            e.typ = 0; e.op = 2; e.wb = 1; e.imm = ((i >> 5) & 32'hFFFFF) * 4096;
        end else if ((i >> 22) == 32'h0A2) begin
            e.typ = 1; e.mem = 2'b01; e.wb = 1; e.imm = sext((i >> 10) & 32'hFFF, 12);
        end else if ((i >> 22) == 32'h0A6) begin
            e.typ = 1; e.op = 1; e.mem = 2'b10; e.ka = i[4:0];
            e.imm = sext((i >> 10) & 32'hFFF, 12);
        end else if ((i >> 26) == 32'h16) begin
            e.typ = 2; e.ka = i[4:0]; e.imm = sext(((i >> 10) & 32'hFFFF) * 4, 18);
        end else if ((i >> 26) == 32'h14) begin
            e.typ = 2; e.op = 1; e.imm = sext(off26 * 4, 28);
        end else if ((i >> 26) == 32'h15) begin
            e.typ = 2; e.op = 2; e.wb = 1; e.rd = 5'd1; e.imm = sext(off26 * 4, 28);
        end else begin
            e.ill = 1;
        end
        if (e.rd == 0) e.wb = 0;
        return e;
    endfunction

    function automatic logic [31:0] wb_hit(input logic [4:0] idx, input logic [31:0] dflt);
        logic [31:0] v = dflt;
        for (int p = 0; p < NWB; p++)
            if (wb_we[p] && wb_idx[5*p +: 5] == idx && idx != 0) v = wb_data[32*p +: 32];
        return v;
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] idx);
        if (idx == 0) return 0;
`ifdef DECODE_WB_BYPASS_EN
        return wb_hit(idx, mregs[idx]);
`else
        return mregs[idx];
`endif
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = sb[0];
                    chk("out_pc", out_pc, e.pc);
                    chk("out_imm", out_imm, e.imm);
                    chk("out_rj", out_rj, e.rj);
                    chk("out_rk", out_rk, e.rk);
                    chk("out_rd_idx", {27'b0, out_rd_idx}, {27'b0, e.rd});
                    chk("out_exe_type", {30'b0, out_exe_type}, {30'b0, e.typ});
                    chk("out_exe_op", {28'b0, out_exe_op}, {28'b0, e.op});
                    chk("out_mem_rw", {30'b0, out_mem_rw}, {30'b0, e.mem});
                    chk("out_wb_valid", {31'b0, out_wb_valid}, {31'b0, e.wb});
                    chk("out_illegal", {31'b0, out_illegal}, {31'b0, e.ill});
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic cycle(input bit iv, input logic [31:0] inst, input logic [31:0] pc,
                         input bit ordy, input bit fl, input logic [NWB-1:0] we,
                         input logic [5*NWB-1:0] idx, input logic [32*NWB-1:0] data);
        exp_t e;
        bit acc;
        @(negedge clk);
        in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
        wb_we = we; wb_idx = idx; wb_data = data;
        #2;
        chk("in_ready", {31'b0, in_ready}, {31'b0, !slot_full || ordy});
        chk("out_valid", {31'b0, out_valid}, {31'b0, slot_full});
        acc = iv && (!slot_full || ordy);
        if (fl) begin
            if (slot_full && !ordy && sb.size() > 0) void'(sb.pop_front());
            slot_full = 0;
        end else if (acc) begin
            e = ref_decode(inst);
            e.pc = pc;
            e.rj = opnd(e.ja);
            e.rk = opnd(e.ka);
            sb.push_back(e);
            slot_full = 1;
        end else if (ordy) begin
            slot_full = 0;
        end else if (slot_full && sb.size() > 0) begin
`ifdef DECODE_WB_BYPASS_EN
            e = sb[0];
            e.rj = wb_hit(e.ja, e.rj);
            e.rk = wb_hit(e.ka, e.rk);
            sb[0] = e;
`endif
        end
        for (int p = 0; p < NWB; p++)
            if (we[p] && idx[5*p +: 5] != 0) mregs[idx[5*p +: 5]] = data[32*p +: 32];
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 9))
            0: return {17'h20, r[14:0]};
            1: return {17'h22, r[14:0]};
            2: return {10'h00A, r[21:0]};
            3: return {7'h0A, r[24:0]};
            4: return {10'h0A2, r[21:0]};
            5: return {10'h0A6, r[21:0]};
            6: return {6'h16, r[25:0]};
            7: return {6'h14, r[25:0]};
            8: return {6'h15, r[25:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        logic [31:0] v6_old, v6_new;
        logic [5*NWB-1:0] ridx;
        for (int r = 0; r < 32; r++) mregs[r] = 0;
        slot_full = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_rj", out_rj, 32'd0);
        chk("rst_out_type", {30'b0, out_exe_type}, 32'd0);
        rst = 1'b0;

        // Accept ADDI.W r4, r0, -1, then backpressure for three cycles
        cycle(1, 32'h02BFFC04, 32'h1000, 0, 0, '0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 32'h00100001, 32'h1004, 0, 0, '0, '0, '0);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("addi_imm", out_imm, 32'hFFFFFFFF);
            chk("addi_rd", {27'b0, out_rd_idx}, 32'd4);
            chk("addi_wb", {31'b0, out_wb_valid}, 32'd1);
            chk("addi_type", {30'b0, out_exe_type}, 32'd0);
        end
        cycle(1, 32'h00100001, 32'h1004, 1, 0, '0, '0, '0);
        cycle(0, 32'h0, 32'h0, 0, 0, '0, '0, '0);
        chk("no_bubble_valid", {31'b0, out_valid}, 32'd1);
        chk("no_bubble_rd", {27'b0, out_rd_idx}, 32'd1);

        // Flush alongside an accept
        cycle(1, 32'h14000061, 32'h2000, 1, 1, '0, '0, '0);
        cycle(0, 32'h0, 32'h0, 1, 0, '0, '0, '0);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);

        // Same-index collision across ports; r0 write ignored
        cycle(0, 32'h0, 32'h0, 1, 0, 2'b11, {5'd5, 5'd5}, {32'h22, 32'h11});
        cycle(1, 32'h001000A8, 32'h3000, 1, 0, 2'b01, {5'd0, 5'd0}, {32'h0, 32'hFF});
        cycle(1, 32'h00100009, 32'h3004, 1, 0, '0, '0, '0);
        chk("collision_r5", out_rj, 32'h22);
        cycle(0, 32'h0, 32'h0, 1, 0, '0, '0, '0);
        chk("r0_rj", out_rj, 32'h0);
        chk("r0_rk", out_rk, 32'h0);

        // Same-cycle and stalled bypass of r6
`ifdef DECODE_WB_BYPASS_EN
        v6_old = 32'hABCD; v6_new = 32'h1234;
`else
        v6_old = 32'h5555; v6_new = 32'h5555;
`endif
        cycle(0, 32'h0, 32'h0, 0, 0, 2'b01, {5'd0, 5'd6}, {32'h0, 32'h5555});
        cycle(1, 32'h001018C7, 32'h4000, 0, 0, 2'b01, {5'd0, 5'd6}, {32'h0, 32'hABCD});
        cycle(0, 32'h0, 32'h0, 0, 0, 2'b10, {5'd6, 5'd0}, {32'h1234, 32'h0});
        chk("byp_accept_rj", out_rj, v6_old);
        chk("byp_accept_rk", out_rk, v6_old);
        cycle(0, 32'h0, 32'h0, 0, 0, '0, '0, '0);
        chk("byp_stall_rj", out_rj, v6_new);
        chk("byp_stall_rk", out_rk, v6_new);
        cycle(0, 32'h0, 32'h0, 1, 0, '0, '0, '0);

        // Illegal word then BL +8
        cycle(1, 32'hFFFFFFFF, 32'h5000, 1, 0, '0, '0, '0);
        cycle(1, 32'h54000800, 32'h5004, 1, 0, '0, '0, '0);
        chk("ill_flag", {31'b0, out_illegal}, 32'd1);
        chk("ill_type", {30'b0, out_exe_type}, 32'd3);
        chk("ill_wb", {31'b0, out_wb_valid}, 32'd0);
        cycle(0, 32'h0, 32'h0, 1, 0, '0, '0, '0);
        chk("bl_rd", {27'b0, out_rd_idx}, 32'd1);
        chk("bl_imm", out_imm, 32'h00000008);

        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < NWB; p++) ridx[5*p +: 5] = 5'($urandom_range(0, 7));
            cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                  NWB'($urandom), ridx, {$urandom, $urandom});
        end

        repeat (3) cycle(0, 32'h0, 32'h0, 1, 0, '0, '0, '0);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
